image_rotator: RTL and testbench

- Consumer end of the rotation-augmentation path: buffers one square image streamed in raster order, then emits it in raster order rotated by 0/90/180/270 degrees clockwise.
- The rotation code comes from the rotation LFSR.
- Once per completed image, the block returns a one-cycle advance pulse that drives the LFSR enable, so each image gets a fresh code.
- Sits between the crop/rescale stage and the training-data output.

---
 rtl/augment_pkg.sv | 16 +
 rtl/image_rotator_if.sv | 26 ++
 rtl/image_rotator_rot_addr_gen.sv | 32 +++
 rtl/image_rotator.sv | 98 +++++++++
 tb/tb_image_rotator.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/augment_pkg.sv
// rtl/augment_pkg.sv - shared types for the rotation-augmentation path
package augment_pkg;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_e;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/image_rotator_if.sv
// rtl/image_rotator_if.sv - pixel in/out handshakes plus LFSR code/advance for the rotator
interface image_rotator_if #(
    parameter int PIX_W = 8
);
    logic [1:0]       degrees;
    logic             rot_next;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic             out_last;

    // Rotator side
    modport slave (
        input  degrees, in_valid, in_pixel, out_ready,
        output rot_next, in_ready, out_valid, out_pixel, out_last
    );

    // Source/sink/LFSR side
    modport master (
        output degrees, in_valid, in_pixel, out_ready,
        input  rot_next, in_ready, out_valid, out_pixel, out_last
    );
endinterface

// File: rtl/image_rotator_rot_addr_gen.sv
// rtl/image_rotator_rot_addr_gen.sv - maps output (row, col) and rotation code to the buffer read address
module rot_addr_gen
    import augment_pkg::*;
#(
    parameter int IMG_DIM = 28
) (
    input  logic [$clog2(IMG_DIM)-1:0]         i,
    input  logic [$clog2(IMG_DIM)-1:0]         j,
    input  rot_e                               rot_q,
    output logic [$clog2(IMG_DIM*IMG_DIM)-1:0] addr
);
    localparam int CW = $clog2(IMG_DIM);
    localparam int AW = $clog2(IMG_DIM*IMG_DIM);
    localparam logic [CW-1:0] DMAX = CW'(IMG_DIM-1);

    logic [CW-1:0] r;
    logic [CW-1:0] c;

    // Clockwise rotation: output (i, j) pulls from the source pixel that lands there
    always_comb begin
        r = i;
        c = j;
        case (rot_q)
            ROT_0:   begin r = i;        c = j;        end
            ROT_90:  begin r = DMAX - j; c = i;        end
            ROT_180: begin r = DMAX - i; c = DMAX - j; end
            ROT_270: begin r = j;        c = DMAX - i; end
            default: begin r = i;        c = j;        end
        endcase
        addr = AW'(r) * AW'(IMG_DIM) + AW'(c);
    end
endmodule

// File: rtl/image_rotator.sv
// rtl/image_rotator.sv - buffers one square image, then emits it rotated by the latched LFSR code
module image_rotator
    import augment_pkg::*;
#(
    parameter int IMG_DIM = 28,
    parameter int PIX_W   = 8
) (
    input logic             clk,
    input logic             reset,
    image_rotator_if.slave  bus
);
    localparam int NPIX = IMG_DIM * IMG_DIM;
    localparam int CW   = $clog2(IMG_DIM);
    localparam int AW   = $clog2(NPIX);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX-1);
    localparam logic [CW-1:0] DMAX      = CW'(IMG_DIM-1);

    state_e           state;
    state_e           state_nx;
    logic [AW-1:0]    wr_cnt;
    logic [AW-1:0]    rd_addr;
    logic [CW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    rot_e             rot_q;
    logic [PIX_W-1:0] mem [NPIX];

    logic in_fire;
    logic out_fire;
    logic last_pix;

    assign in_fire  = bus.in_valid  && (state == LOAD);
    assign out_fire = bus.out_ready && (state == EMIT);
    assign last_pix = (row_q == DMAX) && (col_q == DMAX);

    assign bus.out_last  = (state == EMIT) && last_pix;
    assign bus.rot_next  = out_fire && last_pix;
    assign bus.out_pixel = mem[rd_addr];

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (in_fire && (wr_cnt == LAST_ADDR)) state_nx = EMIT;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                if (out_fire && last_pix) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    // rot_q is sampled only on the final load accept, so it holds for the whole emit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
            row_q  <= '0;
            col_q  <= '0;
            rot_q  <= ROT_0;
        end else begin
            if (in_fire) begin
                if (wr_cnt == LAST_ADDR) begin
                    wr_cnt <= '0;
                    rot_q  <= rot_e'(bus.degrees);
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (out_fire) begin
                if (col_q == DMAX) begin
                    col_q <= '0;
                    row_q <= (row_q == DMAX) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem[wr_cnt] <= bus.in_pixel;
    end

    rot_addr_gen #(.IMG_DIM(IMG_DIM)) u_addr (
        .i     (row_q),
        .j     (col_q),
        .rot_q (rot_q),
        .addr  (rd_addr)
    );
endmodule

// File: tb/tb_image_rotator.sv
// tb/tb_image_rotator.sv - randomized bench for image_rotator against a 2-D rotation model
module tb_image_rotator;
    localparam int D  = 3;
    localparam int N  = D * D;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    image_rotator_if #(.PIX_W(PW)) bif ();

    image_rotator #(.IMG_DIM(D), .PIX_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rn_cnt  = 0;
    int lfsr_steps = 0;

    logic [PW-1:0] img_in  [N];
    logic [PW-1:0] exp_out [N];
    logic [1:0]    deg_drv;
    logic [1:0]    deg_at_accept;
    logic [7:0]    lfsr;
    logic          lfsr_mode;

    assign bif.degrees = lfsr_mode ? lfsr[1:0] : deg_drv;

    always @(negedge clk) if (bif.rot_next === 1'b1) rn_cnt++;

    // Stand-in for the rotation LFSR, enabled by rot_next
    always @(posedge clk) begin
        if (lfsr_mode && bif.rot_next === 1'b1) begin
            lfsr = {lfsr[6:0], 1'b0} ^ (lfsr[7] ? 8'h1D : 8'h00);
            lfsr_steps++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rotate the input image clockwise rot times as a 2-D picture
    task automatic compute_expected(input int rot);
        int cur [D][D];
        int tmp [D][D];
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) cur[r][c] = int'(img_in[r*D+c]);
        for (int n = 0; n < rot; n++) begin
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++) tmp[r][c] = cur[D-1-c][r];
            cur = tmp;
        end
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) exp_out[r*D+c] = PW'(cur[r][c]);
    endtask

    task automatic fill_image(input bit rnd);
        for (int k = 0; k < N; k++) img_in[k] = rnd ? PW'($urandom) : PW'(k);
    endtask

    task automatic send_image(input int n, input int gap_pct);
        int budget;
        for (int k = 0; k < n; k++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bif.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bif.in_valid = 1'b1;
            bif.in_pixel = img_in[k];
            budget = 0;
            forever begin
                @(negedge clk);
                if (bif.in_ready === 1'b1) break;
                budget++;
                if (budget > 100) begin
                    check("in_timeout", 0, 1);
                    bif.in_valid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
            if (k == N-1) deg_at_accept = bif.degrees;
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
        if (n == N) begin
            @(negedge clk);
            check("first_out_valid", bif.out_valid, 1);
            check("in_ready_emit", bif.in_ready, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic recv_image(input int n, input int mode, input int chg_at, input logic [1:0] chg_deg);
        int k = 0;
        int cyc = 0;
        int rn_before = rn_cnt;
        bit held_v = 1'b0;
        logic [PW-1:0] held_p = '0;
        logic held_l = 1'b0;
        while (k < n) begin
            case (mode)
                0:       bif.out_ready = 1'b1;
                1:       bif.out_ready = (cyc % 3 == 0);
                default: bif.out_ready = 1'($urandom_range(1));
            endcase
            if (k == chg_at) deg_drv = chg_deg;
            @(negedge clk);
            check("out_valid_emit", bif.out_valid, 1);
            if (held_v) begin
                check("stall_pixel", bif.out_pixel, held_p);
                check("stall_last", bif.out_last, held_l);
            end
            if (bif.out_ready) begin
                check($sformatf("pix[%0d]", k), bif.out_pixel, exp_out[k]);
                check("out_last", bif.out_last, k == N-1);
                check("rot_next", bif.rot_next, k == N-1);
                k++;
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_p = bif.out_pixel;
                held_l = bif.out_last;
            end
            cyc++;
            if (cyc > 200) begin
                check("out_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        if (n == N) begin
            bif.out_ready = 1'b0;
            @(negedge clk);
            check("in_ready_back", bif.in_ready, 1);
            check("out_valid_done", bif.out_valid, 0);
            check("rot_next_once", rn_cnt - rn_before, 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_image(input logic [1:0] deg, input bit rnd, input int mode, input int gap_pct);
        fill_image(rnd);
        deg_drv = deg;
        send_image(N, gap_pct);
        compute_expected(int'(deg_at_accept));
        recv_image(N, mode, -1, 2'd0);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        check("rst_in_ready", bif.in_ready, 1);
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_rot_next", bif.rot_next, 0);
        check("rst_out_last", bif.out_last, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        lfsr_mode     = 1'b0;
        lfsr          = 8'hA5;
        deg_drv       = 2'd0;
        deg_at_accept = 2'd0;
        bif.in_valid  = 1'b0;
        bif.in_pixel  = '0;
        bif.out_ready = 1'b0;
        #12;
        check("reset_in_ready", bif.in_ready, 1);
        check("reset_out_valid", bif.out_valid, 0);
        check("reset_out_last", bif.out_last, 0);
        check("reset_rot_next", bif.rot_next, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_image(2'd0, 1'b0, 0, 0);
        run_image(2'd1, 1'b0, 0, 0);
        run_image(2'd3, 1'b0, 0, 0);
        run_image(2'd2, 1'b0, 1, 0);

        // degrees moves mid-emit: current image keeps 90 cw, next takes 180
        fill_image(1'b1);
        deg_drv = 2'd1;
        send_image(N, 20);
        compute_expected(int'(deg_at_accept));
        check("deg_latched", deg_at_accept, 1);
        recv_image(N, 2, 4, 2'd2);
        fill_image(1'b1);
        send_image(N, 0);
        check("deg_next", deg_at_accept, 2);
        compute_expected(2);
        recv_image(N, 0, -1, 2'd0);

        lfsr_mode  = 1'b1;
        lfsr_steps = 0;
        for (int m = 0; m < 4; m++) begin
            fill_image(1'b1);
            send_image(N, 25);
            compute_expected(int'(deg_at_accept));
            recv_image(N, 2, -1, 2'd0);
        end
        check("lfsr_steps", lfsr_steps, 4);
        lfsr_mode = 1'b0;

        fill_image(1'b1);
        send_image(5, 0);
        reset_pulse();
        run_image(2'd1, 1'b1, 0, 0);

        fill_image(1'b1);
        deg_drv = 2'd3;
        send_image(N, 0);
        compute_expected(int'(deg_at_accept));
        recv_image(4, 0, -1, 2'd0);
        bif.out_ready = 1'b0;
        reset_pulse();
        run_image(2'd2, 1'b1, 2, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
